// File: rtl/spi_pkg.sv
// Shared definitions for the spi register port and the flash read sequencer:
// register offsets, sequencer state encoding and default flash opcodes.
package spi_pkg;

  localparam logic [2:0] SPI_DATA_END = 3'd0;
  localparam logic [2:0] SPI_DATA     = 3'd1;
  localparam logic [2:0] SPI_READY    = 3'd2;
  localparam logic [2:0] SPI_INT      = 3'd3;
  localparam logic [2:0] SPI_CFG      = 3'd4;

  localparam logic [7:0] DEFAULT_CMD  = 8'h03;
  localparam logic [7:0] DEFAULT_FILL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_WAIT,
    ST_ADDR,
    ST_FILLB,
    ST_CAPT,
    ST_PRES
  } state_t;

endpackage

// File: rtl/spi_flash_reader.sv
// Flash read sequencer: masters the spi register port to send opcode, address
// and fill bytes, and streams the received bytes out with valid/ready.
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter logic [7:0] CMD        = DEFAULT_CMD,
  parameter int         ADDR_BYTES = 3,
  parameter logic [7:0] FILL       = DEFAULT_FILL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_dev,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  output logic        busy,
  output logic [2:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic [7:0]  spi_rdata,
  output logic [1:0]  spi_sel,
  output logic        spi_read,
  output logic        spi_write,
  input  logic        spi_int
);

  // Address is left-aligned so the next byte to send is always [23:16].
  localparam int         ADDR_SHIFT = 8 * (3 - ADDR_BYTES);
  localparam logic [1:0] ADDR_CNT   = 2'(ADDR_BYTES);

  state_t      state_reg, state_next;
  logic [1:0]  dev_reg;
  logic [23:0] addr_reg;
  logic [1:0]  addr_left_reg;
  logic        data_phase_reg;
  logic [8:0]  remaining_reg;
  logic [7:0]  rd_data_reg;
  logic        rd_last_reg;
  logic        last_byte;

  assign last_byte = (remaining_reg == 9'd1);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = ST_CMD;
      ST_CMD,
      ST_ADDR,
      ST_FILLB: state_next = ST_GAP;
      // spi_int may still be stale from the previous byte here
      ST_GAP:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (spi_int) begin
          if (addr_left_reg != 2'd0) state_next = ST_ADDR;
          else if (!data_phase_reg)  state_next = ST_FILLB;
          else                       state_next = ST_CAPT;
        end
      end
      ST_CAPT:  state_next = ST_PRES;
      ST_PRES:  if (rd_ready) state_next = rd_last_reg ? ST_IDLE : ST_FILLB;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_write = 1'b0;
    spi_read  = 1'b0;
    spi_addr  = SPI_DATA_END;
    spi_wdata = 8'h00;
    case (state_reg)
      ST_CMD: begin
        spi_write = 1'b1;
        spi_addr  = SPI_DATA_END;
        spi_wdata = CMD;
      end
      ST_ADDR: begin
        spi_write = 1'b1;
        spi_addr  = SPI_DATA;
        spi_wdata = addr_reg[23:16];
      end
      ST_FILLB: begin
        spi_write = 1'b1;
        spi_addr  = SPI_DATA;
        spi_wdata = FILL;
      end
      ST_CAPT: begin
        // Reading the end register on the final byte releases chip select.
        if (last_byte) begin
          spi_read = 1'b1;
          spi_addr = SPI_DATA_END;
        end else begin
          spi_addr = SPI_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dev_reg        <= 2'd0;
      addr_reg       <= 24'd0;
      addr_left_reg  <= 2'd0;
      data_phase_reg <= 1'b0;
      remaining_reg  <= 9'd0;
      rd_data_reg    <= 8'h00;
      rd_last_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            dev_reg        <= req_dev;
            addr_reg       <= req_addr << ADDR_SHIFT;
            addr_left_reg  <= ADDR_CNT;
            data_phase_reg <= 1'b0;
            remaining_reg  <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
            rd_last_reg    <= 1'b0;
          end
        end
        ST_ADDR: begin
          addr_reg      <= addr_reg << 8;
          addr_left_reg <= addr_left_reg - 2'd1;
        end
        ST_FILLB: data_phase_reg <= 1'b1;
        ST_CAPT: begin
          rd_data_reg <= spi_rdata;
          rd_last_reg <= last_byte;
        end
        ST_PRES: begin
          if (rd_ready) begin
            remaining_reg <= remaining_reg - 9'd1;
            rd_last_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rd_valid  = (state_reg == ST_PRES);
  assign rd_data   = rd_data_reg;
  assign rd_last   = rd_last_reg;
  assign spi_sel   = dev_reg;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader with a behavioural spi register port and a flash
// that returns the low byte of the byte address being read.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_dev;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        busy;
  logic [2:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;
  logic [1:0]  spi_sel;
  logic        spi_read;
  logic        spi_write;
  logic        spi_int;

  always #5 clk = ~clk;

  spi_flash_reader dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dev   (req_dev),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .spi_rdata (spi_rdata),
    .spi_sel   (spi_sel),
    .spi_read  (spi_read),
    .spi_write (spi_write),
    .spi_int   (spi_int)
  );

  // Behavioural spi + flash: 8 shift cycles per byte, int cleared one cycle after a write.
  logic [3:0]  m_cnt;
  logic        m_int, m_clr, m_cs;
  logic [7:0]  m_rx, m_next;
  int          m_idx;
  logic [23:0] m_faddr;
  logic [7:0]  mosi_q[$];
  int          cs_rises = 0;
  int          rd_pulses = 0;
  int          rd_pulses_a0 = 0;

  assign spi_int   = m_int;
  assign spi_rdata = (spi_addr <= 3'd1) ? m_rx : 8'hEE;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 4'd0; m_int <= 1'b0; m_clr <= 1'b0; m_cs <= 1'b0;
      m_rx <= 8'h00; m_next <= 8'h00; m_idx <= 0; m_faddr <= 24'd0;
    end else begin
      m_clr <= 1'b0;
      if (m_clr) m_int <= 1'b0;
      if (m_cnt != 4'd0) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd1) begin
          m_int <= 1'b1;
          m_rx  <= m_next;
        end
      end
      if (spi_write && spi_addr <= 3'd1) begin
        m_clr <= 1'b1;
        m_cnt <= 4'd8;
        mosi_q.push_back(spi_wdata);
        if (spi_addr == 3'd0) begin
          m_idx <= 1;
          if (!m_cs) cs_rises <= cs_rises + 1;
          m_cs <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
        if (m_idx >= 1 && m_idx <= 3) m_faddr <= {m_faddr[15:0], spi_wdata};
        m_next <= (m_idx >= 4) ? 8'(m_faddr + 24'(m_idx - 4)) : 8'h00;
      end
      if (spi_read) begin
        rd_pulses <= rd_pulses + 1;
        if (spi_addr == 3'd0) begin
          rd_pulses_a0 <= rd_pulses_a0 + 1;
          m_cs <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input logic [23:0] addr, input logic [7:0] len);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    for (int k = 0; k < n; k++) sb.push_back('{data: 8'(addr[7:0] + 8'(k)), last: (k == n - 1)});
  endtask

  task automatic start_req(input logic [1:0] dev, input logic [23:0] addr, input logic [7:0] len);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_dev = dev; req_addr = addr; req_len = len;
    push_expect(addr, len);
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("req dev=%0d addr=%06h len=%0d", dev, addr, len);
    chk("busy_after_accept", busy, 1);
    chk("spi_sel_dev", spi_sel, dev);
  endtask

  task automatic drain(input int nbeats, input int stall_beat, input int stall_cycles, input bit expect_locked);
    int    beat;
    int    cyc;
    beat_t e;
    beat = 0; cyc = 0;
    rd_ready = 1'b1;
    while (beat < nbeats && cyc < 8000) begin
      if (rd_valid) begin
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{data: 8'hxx, last: 1'bx};
        if (beat == stall_beat) begin
          rd_ready = 1'b0;
          for (int s = 0; s < stall_cycles; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", rd_valid, 1);
            chk("stall_data", rd_data, e.data);
            chk("stall_sclk_idle", m_cnt, 0);
          end
          rd_ready = 1'b1;
        end
        $display("beat %0d data=%02h last=%0b exp=%02h/%0b", beat, rd_data, rd_last, e.data, e.last);
        chk("rd_data", rd_data, e.data);
        chk("rd_last", rd_last, e.last);
        if (expect_locked) chk("req_ready_while_busy", req_ready, 0);
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("beats_done", beat, nbeats);
    chk("idle_after_last", req_ready, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mosi_base;
    int rp, rp0, csr, cyc;
    logic [7:0] exp_mosi[5];

    reset = 1'b1; req_valid = 1'b0; req_dev = 2'd0; req_addr = 24'd0; req_len = 8'd0;
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_spi_write", spi_write, 0);
    chk("rst_spi_read", spi_read, 0);
    chk("rst_spi_sel", spi_sel, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single byte: check MOSI byte order and chip select framing.
    exp_mosi = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF};
    mosi_base = mosi_q.size();
    csr = cs_rises;
    start_req(2'd0, 24'h123456, 8'd1);
    drain(1, -1, 0, 1'b0);
    chk("mosi_count", mosi_q.size() - mosi_base, 5);
    for (int i = 0; i < 5; i++) begin
      if (mosi_base + i < mosi_q.size()) chk("mosi_byte", mosi_q[mosi_base + i], exp_mosi[i]);
    end
    chk("cs_asserted_once", cs_rises - csr, 1);
    chk("cs_released", m_cs, 0);

    // Four bytes: one terminating read pulse at the end register.
    rp = rd_pulses; rp0 = rd_pulses_a0;
    start_req(2'd2, 24'h0000F0, 8'd4);
    drain(4, -1, 0, 1'b0);
    chk("read_pulses", rd_pulses - rp, 1);
    chk("read_pulses_addr0", rd_pulses_a0 - rp0, 1);

    // Length 0 means 256 bytes.
    start_req(2'd1, 24'h000000, 8'd0);
    drain(256, -1, 0, 1'b0);
    chk("cs_released_256", m_cs, 0);

    // Backpressure on the second beat.
    start_req(2'd0, 24'h000000, 8'd3);
    drain(3, 1, 20, 1'b0);

    // Second request held while busy; accepted only after rd_last.
    start_req(2'd1, 24'h000040, 8'd2);
    req_valid = 1'b1; req_dev = 2'd2; req_addr = 24'h000080; req_len = 8'd1;
    drain(2, -1, 0, 1'b1);
    push_expect(24'h000080, 8'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_req_busy", busy, 1);
    chk("second_req_sel", spi_sel, 2);
    drain(1, -1, 0, 1'b0);

    // Reset during the address phase.
    mosi_base = mosi_q.size();
    start_req(2'd3, 24'hABCDEF, 8'd1);
    cyc = 0;
    while (mosi_q.size() - mosi_base < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("addr_phase_reached", mosi_q.size() - mosi_base, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    $display("mid-transaction reset applied");
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_rd_last", rd_last, 0);
    chk("mrst_spi_write", spi_write, 0);
    chk("mrst_spi_read", spi_read, 0);
    chk("mrst_spi_addr", spi_addr, 0);
    chk("mrst_spi_wdata", spi_wdata, 0);
    chk("mrst_spi_sel", spi_sel, 0);
    chk("mrst_cs", m_cs, 0);
    reset = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    start_req(2'd0, 24'h000777, 8'd1);
    drain(1, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Upstream command engine for the spi block; drives its register port as a bus master, so software does not have to sequence flash reads byte by byte.
- Takes one read request (device, 24-bit address, length) and issues the command byte, the address bytes and the dummy-clocked data bytes through spi's reg port.
- Returns the received data as a valid/ready byte stream.
- Sits between the boot/XIP fetch logic and spi. An external mux grants the spi reg port to this block while busy=1.

Parameters:
- CMD, 8'h03, flash read opcode sent as the first byte.
- ADDR_BYTES, 3, number of address bytes sent MSB first (1..3).
- FILL, 8'hFF, byte driven on MOSI while clocking in data.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&&ready
- req_dev  in  2  spi reg_sel / chip select (3 = no CS, passed through)
- req_addr  in  24  flash byte address
- req_len  in  8  byte count; 0 encodes 256
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts byte
- rd_data  out  8  received byte
- rd_last  out  1  final byte of request
- busy  out  1  reg port owned by this block
- spi_addr  out  3  to spi reg_addr
- spi_wdata  out  8  to spi reg_data_in
- spi_rdata  in  8  from spi reg_data_out
- spi_sel  out  2  to spi reg_sel
- spi_read  out  1  to spi reg_read
- spi_write  out  1  to spi reg_write
- spi_int  in  1  spi interrupt (byte complete)

Behaviour:
- Reset values: state IDLE, req_ready=1, busy=0, rd_valid=0, rd_last=0, spi_read=0, spi_write=0, spi_addr=0, spi_sel=0, spi_wdata=0, byte counters 0. The spi block shares the same reset, so its CS deasserts together with this block's reset.
- spi_write and spi_read are single-cycle pulses. spi_addr and spi_wdata are valid only in the pulse cycle. spi_sel holds the latched dev for the whole transaction.
- States and transitions:
  - IDLE: on req_valid, latch dev/addr/len, then go to CMD. req_ready is 1 only in IDLE.
  - CMD: pulse write, spi_addr=0, wdata=CMD (starts the transaction), then go to GAP.
  - GAP: exactly one cycle. spi_int is ignored here because spi clears it one cycle after the write. Then go to WAIT.
  - WAIT: hold until spi_int=1, then act by phase:
    - Address bytes remaining: go to ADDR.
    - Address phase done and data bytes remaining: go to FILLB.
    - Data phase: go to CAPT.
  - ADDR: pulse write, spi_addr=1, wdata=next address byte (addr[23:16], then [15:8], then [7:0], trimmed to ADDR_BYTES). Then go to GAP.
  - FILLB: pulse write, spi_addr=1, wdata=FILL. Then go to GAP.
  - CAPT, remaining>1: spi_addr=1 with no strobe; register spi_rdata into rd_data; go to PRES.
  - CAPT, remaining==1: pulse read at spi_addr=0 (ends the transaction, spi raises CS); register spi_rdata; set rd_last=1; go to PRES.
  - PRES: rd_valid=1. On rd_ready, decrement remaining. If rd_last, go to IDLE; else go to FILLB.
- Backpressure: no SPI clocking occurs while in PRES, so no bytes are lost and no buffer is needed.
- Byte timing: the next write pulse follows the spi_int detection cycle by exactly 1 cycle. rd_valid rises 2 cycles after spi_int is seen in WAIT.
- Length: 9-bit internal remaining count loaded with (req_len==0 ? 256 : req_len).
- req_valid while busy is ignored; the request must be held until accepted.
- Reset mid-transaction: immediate return to IDLE, and any pending rd byte is dropped.
- spi config (reg_addr 4: clock divider, mode) is owned by software and is never written by this block.

Decomposition:
- Shared package spi_pkg holds:
  - spi register offsets: SPI_DATA_END=0, SPI_DATA=1, SPI_READY=2, SPI_INT=3, SPI_CFG=4.
  - State enum for this FSM.
  - Default CMD and FILL constants.
- No sub-module. A single FSM with an address/remaining counter is natural.

Test Plan:
- dev=0, addr=24'h123456, len=1; real spi instance plus behavioural flash model returning addr[7:0]:
  - MOSI bytes are 03 12 34 56 FF.
  - Exactly one rd beat with rd_data=8'h56 and rd_last=1.
  - CS0 is low only during the transfer; req_ready returns to 1.
- len=4 at addr 24'h0000F0:
  - rd_data sequence is F0 F1 F2 F3 with rd_last only on F3.
  - Exactly one spi_read pulse at spi_addr=0.
- len=0 (256 bytes) at 24'h000000: 256 beats with data 00..FF, rd_last on beat 256, no counter wrap.
- Backpressure: rd_ready held low 20 cycles on beat 2 of len=3:
  - spi_clk idle throughout.
  - rd_data stable at 8'h01.
  - Stream resumes correctly afterwards.
- req_valid with a new request while busy: req_ready=0 and the second request is accepted only after the first completes with rd_last.
- reset asserted mid-address-phase: next cycle all outputs are at reset values, cs=3'b111 and state IDLE; a fresh len=1 request then completes normally.
